toggle_event_rx: RTL and testbench

TOGGLE_EVENT_RX -- requirements
Module: toggle_event_rx

---
 rtl/toggle_event_rx.sv | 112 +++++++++++
 tb/tb_toggle_event_rx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/toggle_event_rx.sv
// Toggle-encoded event receiver: synchronizes t_in, decodes each level change
// into a strobe, and tracks pending (handshaked) and total event counts.
module toggle_event_rx #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned PEND_W      = 4,
   parameter int unsigned CNT_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              t_in,
   input  logic              clr,
   input  logic              evt_ready,
   output logic              evt_pulse,
   output logic              evt_valid,
   output logic [PEND_W-1:0] pend_cnt,
   output logic [CNT_W-1:0]  total_cnt,
   output logic              overflow
);

   localparam int unsigned FILL_W = 3;
   localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

   typedef enum logic {UNARMED, ARMED} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_last;
   logic                   ref_q, ref_d;
   logic [FILL_W-1:0]      fill_q, fill_d;
   logic                   detect_c;
   logic                   accept_c;
   logic                   pulse_d;
   logic [PEND_W-1:0]      pend_d;
   logic [CNT_W-1:0]       total_d;
   logic                   ovf_d;

   assign s_last    = sync_q[SYNC_STAGES-1];
   assign evt_valid = |pend_cnt;
   assign accept_c  = evt_valid && evt_ready;

   // Synchronizer chain; only the last stage is consumed downstream
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], t_in};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= UNARMED;
         fill_q    <= '0;
         ref_q     <= 1'b0;
         evt_pulse <= 1'b0;
         pend_cnt  <= '0;
         total_cnt <= '0;
         overflow  <= 1'b0;
      end else begin
         state_q   <= state_d;
         fill_q    <= fill_d;
         ref_q     <= ref_d;
         evt_pulse <= pulse_d;
         pend_cnt  <= pend_d;
         total_cnt <= total_d;
         overflow  <= ovf_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      fill_d   = fill_q;
      ref_d    = ref_q;
      detect_c = 1'b0;
      pend_d   = pend_cnt;
      total_d  = total_cnt;
      ovf_d    = overflow;

      // Wait until the sync chain holds post-reset samples before trusting s_last
      unique case (state_q)
         UNARMED: begin
            fill_d = fill_q + FILL_W'(1);
            if (fill_q == FILL_W'(SYNC_STAGES)) begin
               ref_d   = s_last;
               fill_d  = '0;
               state_d = ARMED;
            end
         end
         ARMED: begin
            detect_c = (s_last != ref_q);
            ref_d    = s_last;
         end
         default: state_d = UNARMED;
      endcase

      if (detect_c && !accept_c) begin
         if (pend_cnt == PEND_MAX) ovf_d  = 1'b1;
         else                      pend_d = pend_cnt + PEND_W'(1);
      end else if (accept_c && !detect_c) begin
         pend_d = pend_cnt - PEND_W'(1);
      end

      if (detect_c) total_d = total_cnt + CNT_W'(1);

      // Clear wins over counting but does not suppress the strobe
      if (clr) begin
         pend_d  = '0;
         total_d = '0;
         ovf_d   = 1'b0;
      end

      pulse_d = detect_c;
   end

endmodule

// File: tb/tb_toggle_event_rx.sv
// Directed bench for toggle_event_rx at default parameters.
module tb_toggle_event_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic       t_in;
   logic       clr;
   logic       evt_ready;
   logic       evt_pulse;
   logic       evt_valid;
   logic [3:0] pend_cnt;
   logic [7:0] total_cnt;
   logic       overflow;

   int n_cmp = 0;
   int n_err = 0;

   toggle_event_rx dut (
      .clk       (clk),
      .rst       (rst),
      .t_in      (t_in),
      .clr       (clr),
      .evt_ready (evt_ready),
      .evt_pulse (evt_pulse),
      .evt_valid (evt_valid),
      .pend_cnt  (pend_cnt),
      .total_cnt (total_cnt),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic toggle_n(input int n);
      for (int i = 0; i < n; i++) begin
         t_in = ~t_in;
         tick();
      end
   endtask

   initial begin
      int pulses;

      rst = 1'b1; t_in = 1'b1; clr = 1'b0; evt_ready = 1'b0;
      tick(3);
      check("rst_pend",  32'(pend_cnt), 0);
      check("rst_total", 32'(total_cnt), 0);
      check("rst_ovf",   32'(overflow), 0);
      check("rst_valid", 32'(evt_valid), 0);
      check("rst_pulse", 32'(evt_pulse), 0);

      // t_in high through reset release, quiet for 20 cycles
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (evt_pulse) pulses++;
      end
      check("quiet_pulses", 32'(pulses), 0);
      check("quiet_pend",   32'(pend_cnt), 0);
      check("quiet_total",  32'(total_cnt), 0);

      // Single change: strobe appears after the second edge following capture
      t_in = 1'b0;
      tick();
      check("lat_e0_pulse", 32'(evt_pulse), 0);
      tick();
      check("lat_e1_pulse", 32'(evt_pulse), 0);
      tick();
      check("lat_e2_pulse", 32'(evt_pulse), 1);
      check("lat_pend",     32'(pend_cnt), 1);
      check("lat_total",    32'(total_cnt), 1);
      check("lat_valid",    32'(evt_valid), 1);
      tick();
      check("lat_e3_pulse", 32'(evt_pulse), 0);
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      check("drain1_pend", 32'(pend_cnt), 0);

      // Back-to-back toggles give back-to-back strobes
      for (int i = 0; i < 7; i++) begin
         if (i < 4) t_in = ~t_in;
         tick();
         check($sformatf("b2b_pulse%0d", i), 32'(evt_pulse), (i >= 2 && i <= 5) ? 1 : 0);
      end
      check("b2b_pend",  32'(pend_cnt), 4);
      check("b2b_total", 32'(total_cnt), 5);
      evt_ready = 1'b1;
      for (int i = 3; i >= 0; i--) begin
         tick();
         check($sformatf("drain_pend%0d", i), 32'(pend_cnt), 32'(i));
      end
      check("drain_valid", 32'(evt_valid), 0);
      tick();
      check("ready_idle_pend", 32'(pend_cnt), 0);
      evt_ready = 1'b0;

      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr0_total", 32'(total_cnt), 0);

      // Saturation and sticky overflow
      toggle_n(16);
      tick(3);
      check("sat_pend",  32'(pend_cnt), 15);
      check("sat_ovf",   32'(overflow), 1);
      check("sat_total", 32'(total_cnt), 16);
      tick(2);
      check("sat_ovf_sticky", 32'(overflow), 1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_pend",  32'(pend_cnt), 0);
      check("clr_ovf",   32'(overflow), 0);
      check("clr_total", 32'(total_cnt), 0);

      // Simultaneous detect and accept leaves pending unchanged
      toggle_n(2);
      tick(3);
      check("pre_pend",  32'(pend_cnt), 2);
      check("pre_total", 32'(total_cnt), 2);
      t_in = ~t_in;
      tick(2);
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      check("both_pulse", 32'(evt_pulse), 1);
      check("both_pend",  32'(pend_cnt), 2);
      check("both_total", 32'(total_cnt), 3);

      // Total counter wraps silently at 256 events
      toggle_n(252);
      tick(3);
      check("wrap_255", 32'(total_cnt), 255);
      toggle_n(1);
      tick(3);
      check("wrap_total", 32'(total_cnt), 0);
      check("wrap_pend",  32'(pend_cnt), 15);
      check("wrap_ovf",   32'(overflow), 1);

      // Clear coincident with a detect: strobe kept, event not counted
      t_in = ~t_in;
      tick(2);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clrdet_pulse", 32'(evt_pulse), 1);
      check("clrdet_pend",  32'(pend_cnt), 0);
      check("clrdet_total", 32'(total_cnt), 0);

      // Mid-operation reset discards pending events and re-arms
      toggle_n(5);
      tick(3);
      check("prerst_pend", 32'(pend_cnt), 5);
      #3 rst = 1'b1;
      #1;
      check("arst_pend",  32'(pend_cnt), 0);
      check("arst_total", 32'(total_cnt), 0);
      check("arst_valid", 32'(evt_valid), 0);
      tick();
      t_in = ~t_in;
      tick();
      rst = 1'b0;
      t_in = ~t_in;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (evt_pulse) pulses++;
      end
      check("rearm_pulses", 32'(pulses), 0);
      check("rearm_pend",   32'(pend_cnt), 0);
      t_in = ~t_in;
      tick(3);
      check("rearm_evt_pulse", 32'(evt_pulse), 1);
      check("rearm_evt_total", 32'(total_cnt), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
